// File: rtl/timer_scheduler.sv
// timer_scheduler: one countdown timer shared round-robin among NUM_REQ
// requesters. The winner's duration (in ticks of TICK_PERIOD_ns) is latched at
// grant; when it expires a one-cycle done pulse goes to that requester.
//
// Ports:
//   clk          system clock, rising edge
//   sync_resetn  synchronous active-low reset (wins over enable)
//   enable       clock enable; low freezes all state and outputs
//   req          level request per requester
//   req_ticks    packed durations, requester i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   grant        one-hot owner while counting
//   done         one-hot single-cycle completion pulse
//   busy         high whenever not idle
//   active_id    owner / completing requester, 0 when idle
//   remaining    ticks left for the owner, 0 when idle
module timer_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int COUNT_WIDTH    = 16,
  parameter int CLK_PERIOD_ns  = 20,
  parameter int TICK_PERIOD_ns = 1_000_000
) (
  input  logic                       clk,
  input  logic                       sync_resetn,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_ticks,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic [COUNT_WIDTH-1:0]     remaining
);
  localparam int PRESCALE = TICK_PERIOD_ns / CLK_PERIOD_ns;
  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        ptr, ptr_nxt, id_nxt, next_id, winner, cand;
  logic [COUNT_WIDTH-1:0] rem_nxt;
  logic [PS_W-1:0]        ps, ps_nxt;
  logic [NUM_REQ-1:0]     grant_nxt, done_nxt;
  logic                   busy_nxt, found;
  int                     s;

  logic [COUNT_WIDTH-1:0] ticks_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign ticks_arr[i] = req_ticks[i*COUNT_WIDTH +: COUNT_WIDTH];
  end

  // First set request scanning ptr, ptr+1, ... with wrap at NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    s      = 0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      cand = ID_W'(s);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign next_id = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + ID_W'(1);

  // State register: every flop, outputs included, updates only when enabled.
  always_ff @(posedge clk) begin
    if (!sync_resetn) begin
      state     <= IDLE;
      ptr       <= '0;
      ps        <= '0;
      active_id <= '0;
      remaining <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else if (enable) begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      ps        <= ps_nxt;
      active_id <= id_nxt;
      remaining <= rem_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    id_nxt    = active_id;
    rem_nxt   = remaining;
    ps_nxt    = ps;
    case (state)
      IDLE: begin
        if (found) begin
          id_nxt    = winner;
          rem_nxt   = ticks_arr[winner];
          ps_nxt    = '0;
          state_nxt = (ticks_arr[winner] == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        // Dropped request aborts, even on the final tick.
        if (!req[active_id]) begin
          state_nxt = IDLE;
          ptr_nxt   = next_id;
          id_nxt    = '0;
          rem_nxt   = '0;
          ps_nxt    = '0;
        end else if (ps == PS_LAST) begin
          ps_nxt  = '0;
          rem_nxt = remaining - COUNT_WIDTH'(1);
          if (remaining == COUNT_WIDTH'(1)) state_nxt = DONE;
        end else begin
          ps_nxt = ps + PS_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ptr_nxt   = next_id;
        id_nxt    = '0;
        rem_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the next state so the outputs come straight off flops.
  always_comb begin
    grant_nxt = '0;
    done_nxt  = '0;
    busy_nxt  = (state_nxt != IDLE);
    if (state_nxt == COUNT) grant_nxt[id_nxt] = 1'b1;
    if (state_nxt == DONE)  done_nxt[id_nxt]  = 1'b1;
  end

endmodule
